keycode_player: RTL and testbench

Autonomous song playback source that emits keycodes to the note parser, driving the same keycode_new/keycode_old interface the USB keyboard path drives. It reads note entries from a synchronous song ROM, converts each note index back to its keyboard keycode, holds it for the programmed duration, then releases it for a fixed gap. The gap guarantees that repeated notes retrigger. A top-level mux selects between this block and the keyboard.

---
 rtl/keycode_player.sv | 235 +++++++++++++++++++++++
 tb/tb_keycode_player.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keycode_player.sv
// keycode_player
//   Autonomous song playback source. Walks a synchronous song ROM, turns each
//   note index back into its keyboard keycode and drives the same
//   keycode_new/keycode_old pair the USB keyboard path drives. Each entry holds
//   its key for dur*STEP_TICKS cycles and then releases for GAP_CYCLES cycles,
//   so repeated notes always retrigger at the parser.
//
// Parameters
//   ADDR_W      song ROM address width (song length up to 2^ADDR_W entries)
//   STEP_TICKS  Clk cycles per duration tick (>= 1)
//   GAP_CYCLES  release cycles after every entry (>= 2)
//
// Ports
//   Clk, Reset   system clock, synchronous active-high reset
//   Start        level; begins playback at address 0 when idle
//   Stop         level; aborts playback from any state
//   Loop         sampled when an END entry is decoded
//   rom_addr     song ROM address
//   rom_data     ROM word, valid one cycle after rom_addr
//                [15] END, [14] REST, [13:8] note index, [7:0] duration ticks
//   keycode_new  current keycode (8'h00 = no key)
//   keycode_old  keycode_new delayed one Clk
//   Busy         high in every state except IDLE
//   Done         one-cycle pulse on the last gap cycle of a non-looped song
//   BadNote      sticky; an unmappable note was played; cleared on Start
module keycode_player #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned STEP_TICKS = 500000,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        keycode_new,
  output logic [7:0]        keycode_old,
  output logic              Busy,
  output logic              Done,
  output logic              BadNote
);

  localparam int unsigned TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(STEP_TICKS - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_NOTE,
    S_GAP,
    S_END_GAP
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        key_n;
  logic [TW-1:0]     tick_cnt, tick_n;
  logic [7:0]        dur_cnt, dur_n;
  logic [GW-1:0]     gap_cnt, gap_n;
  logic              last_entry, last_n;
  logic              loop_q, loop_n;
  logic              bad_n;

  logic [8:0]        mapped;
  logic              dec_end;
  logic              dec_bad;
  logic [7:0]        dec_key;
  logic [7:0]        dec_dur;
  logic              do_decode;

  // {valid, keycode}; valid=0 for note indices with no key on the keyboard.
  function automatic logic [8:0] note_map(input logic [5:0] note);
    logic [8:0] m;
    m = '0;
    case (note)
      6'd0:  m = {1'b1, 8'h1D};
      6'd2:  m = {1'b1, 8'h1B};
      6'd4:  m = {1'b1, 8'h06};
      6'd5:  m = {1'b1, 8'h04};
      6'd6:  m = {1'b1, 8'h19};
      6'd7:  m = {1'b1, 8'h16};
      6'd8:  m = {1'b1, 8'h05};
      6'd9:  m = {1'b1, 8'h07};
      6'd10: m = {1'b1, 8'h14};
      6'd11: m = {1'b1, 8'h09};
      6'd12: m = {1'b1, 8'h1A};
      6'd13: m = {1'b1, 8'h0A};
      6'd14: m = {1'b1, 8'h08};
      6'd15: m = {1'b1, 8'h0B};
      6'd16: m = {1'b1, 8'h15};
      6'd17: m = {1'b1, 8'h0D};
      6'd18: m = {1'b1, 8'h17};
      6'd19: m = {1'b1, 8'h0E};
      6'd20: m = {1'b1, 8'h1C};
      6'd21: m = {1'b1, 8'h0F};
      6'd22: m = {1'b1, 8'h18};
      6'd23: m = {1'b1, 8'h33};
      6'd24: m = {1'b1, 8'h0C};
      6'd25: m = {1'b1, 8'h34};
      6'd26: m = {1'b1, 8'h12};
      6'd28: m = {1'b1, 8'h13};
      6'd30: m = {1'b1, 8'h2F};
      default: m = '0;
    endcase
    return m;
  endfunction

  // Entry decode, shared by WAIT, the last GAP cycle and a looping END_GAP.
  // last_entry forces END after the top address so no wrap fetch is used.
  always_comb begin
    mapped  = note_map(rom_data[13:8]);
    dec_end = rom_data[15] || last_entry;
    dec_bad = !rom_data[14] && !mapped[8];
    dec_key = (rom_data[14] || !mapped[8]) ? 8'h00 : mapped[7:0];
    dec_dur = (rom_data[7:0] == 8'h00) ? 8'd1 : rom_data[7:0];
  end

  always_comb begin
    state_n   = state;
    addr_n    = rom_addr;
    key_n     = keycode_new;
    tick_n    = tick_cnt;
    dur_n     = dur_cnt;
    gap_n     = gap_cnt;
    last_n    = last_entry;
    loop_n    = loop_q;
    bad_n     = BadNote;
    Done      = 1'b0;
    do_decode = 1'b0;

    if (Stop) begin
      state_n = S_IDLE;
      key_n   = 8'h00;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            state_n = S_FETCH;
            addr_n  = '0;
            bad_n   = 1'b0;
            last_n  = 1'b0;
          end
        end
        S_FETCH: state_n = S_WAIT;
        S_WAIT:  do_decode = 1'b1;
        S_NOTE: begin
          if (tick_cnt == '0) begin
            if (dur_cnt == 8'd0) begin
              state_n = S_GAP;
              key_n   = 8'h00;
              gap_n   = GAP_LOAD;
              if (&rom_addr) last_n = 1'b1;
              else           addr_n = rom_addr + 1'b1;
            end else begin
              dur_n  = dur_cnt - 8'd1;
              tick_n = TICK_LOAD;
            end
          end else begin
            tick_n = tick_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) do_decode = 1'b1;
          else               gap_n = gap_cnt - 1'b1;
        end
        S_END_GAP: begin
          if (gap_cnt == '0) begin
            if (loop_q) begin
              do_decode = 1'b1;
            end else begin
              state_n = S_IDLE;
              Done    = 1'b1;
            end
          end else begin
            gap_n = gap_cnt - 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase

      if (do_decode) begin
        if (dec_end) begin
          // Address 0 is presented right away so a looping seam has the
          // same fetch window as an ordinary gap.
          state_n = S_END_GAP;
          key_n   = 8'h00;
          gap_n   = GAP_LOAD;
          loop_n  = Loop;
          addr_n  = '0;
          last_n  = 1'b0;
        end else begin
          state_n = S_NOTE;
          key_n   = dec_key;
          tick_n  = TICK_LOAD;
          dur_n   = dec_dur - 8'd1;
          if (dec_bad) bad_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      rom_addr    <= '0;
      keycode_new <= '0;
      keycode_old <= '0;
      tick_cnt    <= '0;
      dur_cnt     <= '0;
      gap_cnt     <= '0;
      last_entry  <= 1'b0;
      loop_q      <= 1'b0;
      BadNote     <= 1'b0;
    end else begin
      state       <= state_n;
      rom_addr    <= addr_n;
      keycode_new <= key_n;
      keycode_old <= keycode_new;
      tick_cnt    <= tick_n;
      dur_cnt     <= dur_n;
      gap_cnt     <= gap_n;
      last_entry  <= last_n;
      loop_q      <= loop_n;
      BadNote     <= bad_n;
    end
  end

  assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_keycode_player.sv
// Bench for keycode_player: small ROM, STEP_TICKS=4, GAP_CYCLES=4, ADDR_W=4.
// A queue-based song expander predicts every output cycle; directed songs pin
// hand-computed values, then randomized songs and control inputs follow.
module tb_keycode_player;
  localparam int unsigned AW   = 4;
  localparam int unsigned STEP = 4;
  localparam int unsigned GAP  = 4;
  localparam int          NENT = 16;

  logic          Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Stop = 1'b0, Loop = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = '0;
  logic [7:0]    keycode_new, keycode_old;
  logic          Busy, Done, BadNote;
  logic [15:0]   rom [0:NENT-1];

  keycode_player #(.ADDR_W(AW), .STEP_TICKS(STEP), .GAP_CYCLES(GAP)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Loop(Loop),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .keycode_new(keycode_new), .keycode_old(keycode_old),
    .Busy(Busy), .Done(Done), .BadNote(BadNote)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) rom_data <= rom[rom_addr];

  int passed = 0, total = 0;
  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  int mn [27] = '{0,2,4,5,6,7,8,9,10,11,12,13,14,15,16,17,18,19,20,21,22,23,24,25,26,28,30};
  int mk [27] = '{'h1D,'h1B,'h06,'h04,'h19,'h16,'h05,'h07,'h14,'h09,'h1A,'h0A,'h08,'h0B,
                  'h15,'h0D,'h17,'h0E,'h1C,'h0F,'h18,'h33,'h0C,'h34,'h12,'h13,'h2F};
  int map_tab [64];

  typedef struct { logic [7:0] key; bit bad; bit efirst; bit elast; } item_t;
  item_t q[$];
  bit         m_play = 0, m_fin = 0, m_loop = 0, m_bad = 0, m_dslot = 0;
  int         m_idx = 0;
  logic [7:0] m_key = '0, m_old = '0;
  bit         cmp_en = 0;

  // Append the cycle-by-cycle outputs of the next song entry.
  function automatic void expand();
    item_t      it;
    logic [15:0] w;
    int         d, k;
    bit         bad;
    if (m_idx >= NENT || rom[m_idx][15]) begin
      for (int i = 0; i < GAP; i++) begin
        it = '{key: 8'h00, bad: 0, efirst: (i == 0), elast: (i == GAP-1)};
        q.push_back(it);
      end
    end else begin
      w   = rom[m_idx];
      d   = (w[7:0] == 0) ? 1 : int'(w[7:0]);
      k   = map_tab[w[13:8]];
      bad = !w[14] && (k < 0);
      for (int i = 0; i < d*STEP; i++) begin
        it = '{key: (w[14] || k < 0) ? 8'h00 : 8'(k), bad: (i == 0) && bad, efirst: 0, elast: 0};
        q.push_back(it);
      end
      for (int i = 0; i < GAP; i++) begin
        it = '{key: 8'h00, bad: 0, efirst: 0, elast: 0};
        q.push_back(it);
      end
      m_idx++;
    end
  endfunction

  always @(posedge Clk) begin
    item_t it;
    m_old   = m_key;
    m_dslot = 0;
    if (Reset) begin
      m_play = 0; m_fin = 0; q.delete(); m_key = 8'h00; m_old = 8'h00; m_bad = 0;
    end else if (Stop) begin
      m_play = 0; m_fin = 0; q.delete(); m_key = 8'h00;
    end else if (m_fin) begin
      m_play = 0; m_fin = 0; m_key = 8'h00;
    end else if (!m_play && Start) begin
      m_play = 1; m_bad = 0; m_idx = 0;
      it = '{key: 8'h00, bad: 0, efirst: 0, elast: 0};
      q.push_back(it);
      q.push_back(it);
    end
    if (m_play && !m_fin) begin
      if (q.size() == 0) expand();
      it = q.pop_front();
      m_key = it.key;
      if (it.bad) m_bad = 1;
      if (it.efirst) begin m_loop = Loop; m_idx = 0; end
      if (it.elast && !m_loop) begin m_fin = 1; m_dslot = 1; end
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("keycode_new", keycode_new, m_key);
      chk("keycode_old", keycode_old, m_old);
      chk("Busy", Busy, m_play);
      chk("Done", Done, m_dslot && !Stop);
      chk("BadNote", BadNote, m_bad);
    end
  end

  int done_cnt = 0;
  always @(negedge Clk) if (Done) done_cnt++;

  // ---------------- stimulus helpers ----------------
  int c = 0;
  task automatic goto_cyc(int k);
    while (c < k) begin @(negedge Clk); c++; end
  endtask

  // Start is high for exactly one edge; returns inside cycle 1 (FETCH).
  task automatic start_pulse();
    @(negedge Clk); #1 Start = 1'b1;
    @(negedge Clk); #1 Start = 1'b0;
    c = 1;
  endtask

  task automatic wait_idle(int lim);
    int n = 0;
    while ((Busy || m_play) && n < lim) begin @(negedge Clk); n++; end
    if (n >= lim) chk("idle_timeout", 0, 1);
    @(negedge Clk); #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < NENT; i++) rom[i] = 16'h8000;
  endtask

  logic [7:0] exp_rep [16] = '{8'h1A,8'h1A,8'h1A,8'h1A,8'h00,8'h00,8'h00,8'h00,
                               8'h1A,8'h1A,8'h1A,8'h1A,8'h00,8'h00,8'h00,8'h00};

  initial begin
    for (int i = 0; i < 64; i++) map_tab[i] = -1;
    for (int i = 0; i < 27; i++) map_tab[mn[i]] = mk[i];
    clear_rom();

    repeat (3) @(negedge Clk);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_key_new", keycode_new, 0);
    chk("reset_key_old", keycode_old, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_bad", BadNote, 0);
    #1 Reset = 1'b0;
    cmp_en = 1;

    // single note
    rom[0] = 16'h0002; rom[1] = 16'h8000; done_cnt = 0;
    start_pulse();
    chk("s1_fetch_addr", rom_addr, 0);
    chk("s1_fetch_busy", Busy, 1);
    goto_cyc(3);  chk("s1_key_first", keycode_new, 8'h1D);
    goto_cyc(10); chk("s1_key_last", keycode_new, 8'h1D);
    goto_cyc(11); chk("s1_gap", keycode_new, 8'h00);
    goto_cyc(18); chk("s1_done", Done, 1);
    goto_cyc(19); chk("s1_busy_fall", Busy, 0);
    goto_cyc(20); chk("s1_done_count", done_cnt, 1);

    // repeated note retrigger
    clear_rom(); rom[0] = 16'h0C01; rom[1] = 16'h0C01;
    start_pulse();
    for (int i = 0; i < 16; i++) begin
      goto_cyc(3 + i);
      chk("rep_key_new", keycode_new, exp_rep[i]);
      chk("rep_key_old", keycode_old, (i == 0) ? 8'h00 : exp_rep[i-1]);
    end
    wait_idle(100);

    // rest, bad note, good note
    clear_rom(); rom[0] = 16'h4001; rom[1] = 16'h0301; rom[2] = 16'h1E01;
    start_pulse();
    goto_cyc(10); chk("rb_bad_before", BadNote, 0);
    goto_cyc(11); chk("rb_bad_set", BadNote, 1);
    chk("rb_bad_silent", keycode_new, 8'h00);
    goto_cyc(18); chk("rb_gap", keycode_new, 8'h00);
    goto_cyc(19); chk("rb_key_2f", keycode_new, 8'h2F);
    goto_cyc(30); chk("rb_done", Done, 1);
    wait_idle(100);
    chk("rb_bad_sticky", BadNote, 1);

    // loop
    clear_rom(); rom[0] = 16'h0501; done_cnt = 0; Loop = 1'b1;
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      goto_cyc(3 + 12*i); chk("loop_key", keycode_new, 8'h04);
    end
    goto_cyc(50); #1 Loop = 1'b0;
    goto_cyc(51); chk("loop_last_key", keycode_new, 8'h04);
    chk("loop_no_done", done_cnt, 0);
    goto_cyc(62); chk("loop_done", Done, 1);
    goto_cyc(63); chk("loop_busy_fall", Busy, 0);

    // stop mid-note, then restart
    clear_rom(); rom[0] = 16'h0301; rom[1] = 16'h0003; done_cnt = 0;
    start_pulse();
    goto_cyc(3);  chk("stop_bad", BadNote, 1);
    goto_cyc(13); chk("stop_key_pre", keycode_new, 8'h1D);
    #1 Stop = 1'b1;
    goto_cyc(14); chk("stop_key", keycode_new, 8'h00);
    chk("stop_busy", Busy, 0);
    #1 Stop = 1'b0;
    goto_cyc(15); chk("stop_bad_kept", BadNote, 1);
    chk("stop_no_done", done_cnt, 0);
    start_pulse();
    chk("restart_addr", rom_addr, 0);
    chk("restart_bad_clr", BadNote, 0);
    wait_idle(100);

    // start while busy, reset mid-gap
    clear_rom(); rom[0] = 16'h0701; rom[1] = 16'h0902;
    start_pulse();
    goto_cyc(4); #1 Start = 1'b1;
    goto_cyc(5); #1 Start = 1'b0;
    goto_cyc(7);  chk("sb_gap", keycode_new, 8'h00);
    goto_cyc(11); chk("sb_next", keycode_new, 8'h07);
    goto_cyc(20); #1 Reset = 1'b1;
    goto_cyc(21);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_key_new", keycode_new, 0);
    chk("rst_key_old", keycode_old, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_bad", BadNote, 0);
    #1 Reset = 1'b0;

    // Stop wins over Start in IDLE
    @(negedge Clk); #1 Start = 1'b1; Stop = 1'b1;
    @(negedge Clk); chk("stop_wins_busy", Busy, 0);
    #1 Start = 1'b0; Stop = 1'b0;

    // full ROM without END: top address ends the song
    for (int i = 0; i < NENT; i++) rom[i] = {2'b00, 6'(mn[i]), 8'h01};
    rom[15] = 16'h1E01;
    start_pulse();
    goto_cyc(123); chk("top_key", keycode_new, 8'h2F);
    goto_cyc(127); chk("top_gap", keycode_new, 8'h00);
    goto_cyc(134); chk("top_done", Done, 1);
    goto_cyc(135); chk("top_busy_fall", Busy, 0);

    // randomized songs and control
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < NENT; i++) begin
        int r, n;
        r = $urandom_range(0, 99);
        n = $urandom_range(0, 63);
        if (r < 75) n = mn[$urandom_range(0, 26)];
        rom[i] = {(r >= 95) ? 1'b1 : 1'b0, (r >= 85 && r < 95) ? 1'b1 : 1'b0,
                  6'(n), 8'($urandom_range(0, 3))};
      end
      Loop = ($urandom_range(0, 3) == 0);
      start_pulse();
      repeat ($urandom_range(20, 300)) begin
        @(negedge Clk); #1;
        Start = ($urandom_range(0, 15) == 0);
        Stop  = ($urandom_range(0, 199) == 0);
        Reset = ($urandom_range(0, 499) == 0);
        if ($urandom_range(0, 29) == 0) Loop = ~Loop;
      end
      @(negedge Clk); #1 Start = 1'b0; Reset = 1'b0; Stop = 1'b1;
      @(negedge Clk); #1 Stop = 1'b0;
      wait_idle(50);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
